// File: rtl/bumpy_pkg.sv
// Shared tile encoding, area indices and fixed-point helpers for the Bumpy
// motion engine and the tile/step controller.
package bumpy_pkg;

  typedef logic [2:0] tile_t;

  localparam tile_t FREE  = 3'd0;
  localparam tile_t REGU  = 3'd1;
  localparam tile_t GATE  = 3'd2;
  localparam tile_t DEATH = 3'd3;
  localparam tile_t WALL  = 3'd4;
  localparam tile_t SPIKE = 3'd5;
  localparam tile_t BRAKE = 3'd6;

  localparam int AREA_LEFT  = 0;
  localparam int AREA_UP    = 1;
  localparam int AREA_RIGHT = 2;
  localparam int AREA_DOWN  = 3;

  localparam int FP_SHIFT = 6;
  // One 64-pixel tile expressed in fixed point (64 * 64 = 1 << 12)
  localparam int TILE_SHIFT = 12;
  localparam int TILE_FP    = 1 << TILE_SHIFT;

  typedef enum logic [1:0] {StWait, StPlay, StDying} state_t;

  // Round a non-negative fixed-point coordinate down to its tile boundary
  function automatic logic signed [31:0] tile_floor(input logic signed [31:0] v);
    return {v[31:TILE_SHIFT], {TILE_SHIFT{1'b0}}};
  endfunction

  // Round a non-negative fixed-point coordinate up to a tile boundary
  function automatic logic signed [31:0] tile_ceil(input logic signed [31:0] v);
    return tile_floor(v + (TILE_FP - 1));
  endfunction

endpackage

// File: rtl/bumpy_tile_class.sv
// Decodes one neighbour tile type into the collision classes used by physics.
module bumpy_tile_class
  import bumpy_pkg::*;
(
  input  logic [2:0] tile,
  output logic       is_solid,
  output logic       is_lethal,
  output logic       is_gate,
  output logic       is_brake
);

  // Tile type to class flags; unknown encodings are passable
  always_comb begin
    is_solid  = 1'b0;
    is_lethal = 1'b0;
    is_gate   = 1'b0;
    is_brake  = 1'b0;
    case (tile)
      REGU, WALL: is_solid = 1'b1;
      GATE: begin
        is_solid = 1'b1;
        is_gate  = 1'b1;
      end
      BRAKE: begin
        is_solid = 1'b1;
        is_brake = 1'b1;
      end
      SPIKE, DEATH: is_lethal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bumpy_motion.sv
// Per-frame motion/physics engine for the Bumpy sprite.
// Three-step frame pipeline: sample (N), velocity (N+1), position/collision (N+2).
// Optional: define BUMPY_BRAKE_TILE_EN to give BRAKE tiles a half-height bounce.
module bumpy_motion
  import bumpy_pkg::*;
#(
  parameter int INITIAL_X    = 64,
  parameter int INITIAL_Y    = 256,
  parameter int BUMPY_SIZE   = 32,
  parameter int GRAVITY      = 4,
  parameter int JUMP_SPEED   = 384,
  parameter int MAX_FALL     = 512,
  parameter int X_SPEED      = 128,
  parameter int DEATH_FRAMES = 60,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 448
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            startOfFrame,
  input  logic            start,
  input  logic            left_key,
  input  logic            right_key,
  input  logic [3:0][2:0] area,
  output logic [10:0]     bumpy_x,
  output logic [10:0]     bumpy_y,
  output logic            death,
  output logic            level_done,
  output logic            active
);

  localparam int SIZE_FP = BUMPY_SIZE << FP_SHIFT;
  localparam int SPAWN_X = INITIAL_X << FP_SHIFT;
  localparam int SPAWN_Y = INITIAL_Y << FP_SHIFT;
  localparam int X_MAX   = (SCREEN_W - BUMPY_SIZE) << FP_SHIFT;
  localparam int Y_LIMIT = SCREEN_H << FP_SHIFT;
  localparam int CNT_W   = $clog2(DEATH_FRAMES + 1);

  state_t                    state_q, state_d;
  logic signed [31:0]        x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic                      death_q, death_d, done_q, done_d;
  logic        [3:0][2:0]    area_q;
  logic                      left_q, right_q;
  logic                      vel_q, pos_q;
  logic        [3:0]         solid, lethal, gate, brake;

  for (genvar i = 0; i < 4; i++) begin : g_class
    bumpy_tile_class u_class (
      .tile      (area_q[i]),
      .is_solid  (solid[i]),
      .is_lethal (lethal[i]),
      .is_gate   (gate[i]),
      .is_brake  (brake[i])
    );
  end

  logic unused_class;
  assign unused_class = ^{lethal[AREA_UP], gate[2:0], brake};

  logic signed [31:0] nx, ny, vy_hit, left_bnd, right_bnd, top_bnd, bot_bnd;
  logic               land, fell;

  // Candidate position after this frame's move, with wall/ceiling/floor clamps
  always_comb begin
    nx        = x_q + vx_q;
    ny        = y_q + vy_q;
    vy_hit    = vy_q;
    left_bnd  = tile_floor(x_q);
    right_bnd = tile_ceil(x_q + SIZE_FP);
    top_bnd   = tile_floor(y_q);
    bot_bnd   = tile_ceil(y_q + SIZE_FP);
    // Lethal side tiles block like walls
    if (vx_q < 0 && (solid[AREA_LEFT] || lethal[AREA_LEFT]) && nx < left_bnd) begin
      nx = left_bnd;
    end
    if (vx_q > 0 && (solid[AREA_RIGHT] || lethal[AREA_RIGHT]) &&
        nx + SIZE_FP > right_bnd) begin
      nx = right_bnd - SIZE_FP;
    end
    if (nx < 0) begin
      nx = '0;
    end else if (nx > X_MAX) begin
      nx = X_MAX;
    end
    // Falling out is judged on the unclamped move so a floor cannot hide it
    fell = ny + SIZE_FP > Y_LIMIT;
    land = vy_q > 0 && (solid[AREA_DOWN] || lethal[AREA_DOWN]) && ny + SIZE_FP >= bot_bnd;
    if (land) begin
      ny = bot_bnd - SIZE_FP;
    end else if (vy_q < 0 && solid[AREA_UP] && ny < top_bnd) begin
      ny     = top_bnd;
      vy_hit = '0;
    end
    if (ny < 0) begin
      ny     = '0;
      vy_hit = '0;
    end
  end

  // Next state: start handling, frame physics, death countdown and respawn
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cnt_d   = cnt_q;
    death_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StWait: begin
        if (start) begin
          state_d = StPlay;
          vy_d    = '0;
        end
      end
      StPlay: begin
        if (vel_q) begin
          vx_d = (left_q && !right_q) ? -X_SPEED : ((right_q && !left_q) ? X_SPEED : 0);
          vy_d = (vy_q + GRAVITY > MAX_FALL) ? MAX_FALL : vy_q + GRAVITY;
        end else if (pos_q) begin
          if (fell || (land && lethal[AREA_DOWN])) begin
            // Position freezes where it was before the fatal move
            death_d = 1'b1;
            state_d = StDying;
            cnt_d   = CNT_W'(DEATH_FRAMES);
          end else if (land && gate[AREA_DOWN]) begin
            done_d  = 1'b1;
            state_d = StWait;
            x_d     = SPAWN_X;
            y_d     = SPAWN_Y;
            vx_d    = '0;
            vy_d    = '0;
          end else begin
            x_d  = nx;
            y_d  = ny;
            vy_d = vy_hit;
            if (land) begin
              vy_d = -JUMP_SPEED;
`ifdef BUMPY_BRAKE_TILE_EN
              if (brake[AREA_DOWN]) begin
                vy_d = -(JUMP_SPEED >>> 1);
                vx_d = vx_q >>> 1;
              end
`endif
            end
          end
        end
      end
      StDying: begin
        if (startOfFrame) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = StWait;
            cnt_d   = '0;
            x_d     = SPAWN_X;
            y_d     = SPAWN_Y;
            vx_d    = '0;
            vy_d    = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = StWait;
    endcase
  end

  // State, kinematics and pulse registers; reset aborts a frame in flight
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StWait;
      x_q     <= SPAWN_X;
      y_q     <= SPAWN_Y;
      vx_q    <= '0;
      vy_q    <= '0;
      cnt_q   <= '0;
      death_q <= 1'b0;
      done_q  <= 1'b0;
      area_q  <= '0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      vel_q   <= 1'b0;
      pos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      cnt_q   <= cnt_d;
      death_q <= death_d;
      done_q  <= done_d;
      vel_q   <= startOfFrame && (state_q == StPlay);
      pos_q   <= vel_q;
      if (startOfFrame) begin
        area_q  <= area;
        left_q  <= left_key;
        right_q <= right_key;
      end
    end
  end

  assign bumpy_x    = x_q[FP_SHIFT +: 11];
  assign bumpy_y    = y_q[FP_SHIFT +: 11];
  assign death      = death_q;
  assign level_done = done_q;
  assign active     = (state_q == StPlay);

endmodule

// File: tb/tb_bumpy_motion.sv
// Self-checking bench for bumpy_motion with a frame-level behavioural model.
module tb_bumpy_motion;

  logic            clk = 1'b0;
  logic            resetN, startOfFrame, start, left_key, right_key;
  logic [3:0][2:0] area;
  logic [10:0]     bumpy_x, bumpy_y;
  logic            death, level_done, active;

  int checks = 0;
  int errors = 0;

  bumpy_motion dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .start        (start),
    .left_key     (left_key),
    .right_key    (right_key),
    .area         (area),
    .bumpy_x      (bumpy_x),
    .bumpy_y      (bumpy_y),
    .death        (death),
    .level_done   (level_done),
    .active       (active)
  );

  always #5 clk = ~clk;

  // Model state: positions/velocities in pixel*64; m_state 0=wait 1=play 2=dying
  int m_x, m_y, m_vx, m_vy, m_cnt, m_state;
  bit e_death, e_done;

  // Samples taken by run_frame
  logic [10:0] pre_x, pre_y, mid_x, mid_y, o_x, o_y;
  logic        o_death, o_done, o_active;

  function automatic bit t_solid(input logic [2:0] t);
    return t inside {3'd1, 3'd2, 3'd4, 3'd6};
  endfunction

  function automatic bit t_lethal(input logic [2:0] t);
    return t inside {3'd3, 3'd5};
  endfunction

  function automatic int fl(input int v);
    return (v / 4096) * 4096;
  endfunction

  function automatic int cl(input int v);
    return ((v + 4095) / 4096) * 4096;
  endfunction

  function automatic logic [10:0] px(input int v);
    return 11'(v >>> 6);
  endfunction

  function automatic logic [3:0][2:0] mk_area(input logic [2:0] lt, up, rt, dn);
    return {dn, rt, up, lt};
  endfunction

  function automatic logic [2:0] rnd_tile(input int pct_free);
    if ($urandom_range(0, 99) < pct_free) return 3'd0;
    return 3'($urandom_range(1, 6));
  endfunction

  task automatic model_respawn();
    m_x = 64 * 64; m_y = 256 * 64; m_vx = 0; m_vy = 0;
  endtask

  task automatic model_reset();
    model_respawn();
    m_state = 0; m_cnt = 0;
  endtask

  // One frame of game rules, in pixel*64 integers
  task automatic model_frame(input logic [3:0][2:0] a, input logic l, r, st);
    int nx, ny, nvy;
    bit land, fell;
    e_death = 0; e_done = 0;
    if (m_state == 0) begin
      if (st) begin m_state = 1; m_vy = 0; end
    end else if (m_state == 2) begin
      m_cnt--;
      if (m_cnt == 0) begin model_respawn(); m_state = 0; end
    end else begin
      m_vx = (l && !r) ? -128 : ((r && !l) ? 128 : 0);
      m_vy = (m_vy + 4 > 512) ? 512 : m_vy + 4;
      nx = m_x + m_vx; ny = m_y + m_vy; nvy = m_vy;
      if (m_vx < 0 && (t_solid(a[0]) || t_lethal(a[0])) && nx < fl(m_x)) nx = fl(m_x);
      if (m_vx > 0 && (t_solid(a[2]) || t_lethal(a[2])) && nx + 2048 > cl(m_x + 2048))
        nx = cl(m_x + 2048) - 2048;
      if (nx < 0) nx = 0;
      if (nx > (640 - 32) * 64) nx = (640 - 32) * 64;
      fell = ny + 2048 > 448 * 64;
      land = m_vy > 0 && (t_solid(a[3]) || t_lethal(a[3])) && ny + 2048 >= cl(m_y + 2048);
      if (land) ny = cl(m_y + 2048) - 2048;
      else if (m_vy < 0 && t_solid(a[1]) && ny < fl(m_y)) begin ny = fl(m_y); nvy = 0; end
      if (ny < 0) begin ny = 0; nvy = 0; end
      if (fell || (land && t_lethal(a[3]))) begin
        e_death = 1; m_state = 2; m_cnt = 60;
      end else if (land && a[3] == 3'd2) begin
        e_done = 1; m_state = 0; model_respawn();
      end else begin
        m_x = nx; m_y = ny; m_vy = land ? -384 : nvy;
`ifdef BUMPY_BRAKE_TILE_EN
        if (land && a[3] == 3'd6) begin m_vy = -192; m_vx = m_vx / 2; end
`endif
      end
    end
  endtask

  // Drive one startOfFrame, sample after N+1 and after N+2, then advance the model
  task automatic run_frame(input logic [3:0][2:0] a, input logic l, r, st);
    pre_x = px(m_x); pre_y = px(m_y);
    @(negedge clk);
    area = a; left_key = l; right_key = r; start = st; startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    mid_x = bumpy_x; mid_y = bumpy_y;
    @(posedge clk); #1;
    o_x = bumpy_x; o_y = bumpy_y; o_death = death; o_done = level_done; o_active = active;
    model_frame(a, l, r, st);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (m_state == 0) begin m_state = 1; m_vy = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk); resetN = 1'b0;
    @(negedge clk); resetN = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk); resetN = 1'b0; #1;
    checks++;
    if ({bumpy_x, bumpy_y, death, level_done, active} !== {11'd64, 11'd256, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got x=%0d y=%0d d=%b g=%b a=%b want 64 256 0 0 0",
               bumpy_x, bumpy_y, death, level_done, active);
    end
    @(negedge clk); resetN = 1'b1;
    model_reset();
    pulse_start();
    #1; checks++;
    if (active !== 1'b1) begin
      errors++; $display("FAIL start_active: got %b want 1", active);
    end
  endtask

  task automatic test_fall();
    logic [10:0] prev;
    prev = 11'd256;
    for (int i = 1; i <= 20; i++) begin
      run_frame('0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mid_y !== pre_y) begin
        errors++; $display("FAIL fall_early f%0d: got %0d want %0d", i, mid_y, pre_y);
      end
      checks++;
      if (o_y !== px(m_y) || o_y < prev) begin
        errors++; $display("FAIL fall_y f%0d: got %0d want %0d", i, o_y, px(m_y));
      end
      prev = o_y;
    end
    // 4*(1+..+20) = 840 fixed units below 256 px
    checks++;
    if (o_y !== 11'd269) begin
      errors++; $display("FAIL fall_total: got %0d want 269", o_y);
    end
  endtask

  task automatic test_land_regu();
    do_reset();
    pulse_start();
    for (int i = 1; i <= 33; i++) begin
      run_frame(mk_area(3'd0, 3'd0, 3'd0, 3'd1), 1'b0, 1'b0, 1'b0);
      if (i == 32) begin
        checks++;
        if (o_y !== 11'd288) begin
          errors++; $display("FAIL land_clamp: got %0d want 288", o_y);
        end
      end
      if (i == 33) begin
        checks++;
        if (o_y !== 11'd282) begin
          errors++; $display("FAIL land_bounce: got %0d want 282", o_y);
        end
      end
    end
  endtask

  task automatic test_spike_death();
    do_reset();
    pulse_start();
    for (int i = 1; i <= 32; i++) run_frame(mk_area(3'd0, 3'd0, 3'd0, 3'd5), 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_death, o_done, o_active} !== 3'b100) begin
      errors++; $display("FAIL spike_pulse: got d=%b g=%b a=%b want 1 0 0", o_death, o_done, o_active);
    end
    @(posedge clk); #1;
    checks++;
    if (death !== 1'b0) begin
      errors++; $display("FAIL spike_one_cycle: got %b want 0", death);
    end
    for (int i = 1; i <= 59; i++) run_frame('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_x, o_y, o_active} !== {11'd64, 11'd287, 1'b0}) begin
      errors++; $display("FAIL dying_frozen: got %0d,%0d a=%b want 64,287 0", o_x, o_y, o_active);
    end
    run_frame('0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({o_x, o_y, o_active, o_death} !== {11'd64, 11'd256, 2'b00}) begin
      errors++; $display("FAIL respawn: got %0d,%0d a=%b want 64,256 0", o_x, o_y, o_active);
    end
  endtask

  task automatic test_gate_vs_fall();
    int pv;
    bit hit;
    do_reset();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 120 && !hit; i++) begin
      pv = (m_vy + 4 > 512) ? 512 : m_vy + 4;
      if (m_y + pv + 2048 > 448 * 64) begin
        hit = 1;
        run_frame(mk_area(3'd0, 3'd0, 3'd0, 3'd2), 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_death, o_done} !== 2'b10) begin
          errors++; $display("FAIL gate_vs_fall: got d=%b g=%b want 1 0", o_death, o_done);
        end
      end else begin
        run_frame('0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({o_y, o_death} !== {px(m_y), 1'b0}) begin
          errors++; $display("FAIL gate_fall_y f%0d: got %0d want %0d", i, o_y, px(m_y));
        end
      end
    end
  endtask

  task automatic test_wall();
    do_reset();
    pulse_start();
    for (int i = 0; i < 8; i++) run_frame('0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_x !== 11'd80) begin
      errors++; $display("FAIL wall_approach: got %0d want 80", o_x);
    end
    for (int i = 0; i < 12; i++) begin
      run_frame(mk_area(3'd0, 3'd0, 3'd4, 3'd0), 1'b0, 1'b1, 1'b0);
      checks++;
      if (o_x !== px(m_x)) begin
        errors++; $display("FAIL wall_x f%0d: got %0d want %0d", i, o_x, px(m_x));
      end
    end
    checks++;
    if (o_x !== 11'd96) begin
      errors++; $display("FAIL wall_stop: got %0d want 96", o_x);
    end
    for (int i = 0; i < 3; i++) run_frame('0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_x !== 11'd96) begin
      errors++; $display("FAIL both_keys: got %0d want 96", o_x);
    end
    run_frame('0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_x !== 11'd94) begin
      errors++; $display("FAIL left_move: got %0d want 94", o_x);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    pulse_start();
    run_frame('0, 1'b0, 1'b1, 1'b0);
    run_frame('0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    area = '0; right_key = 1'b1; startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); resetN = 1'b0; #1;
    checks++;
    if ({bumpy_x, bumpy_y, death, level_done, active} !== {11'd64, 11'd256, 3'b000}) begin
      errors++; $display("FAIL midreset_low: got x=%0d y=%0d a=%b want 64 256 0", bumpy_x, bumpy_y, active);
    end
    @(posedge clk); #1;
    checks++;
    if ({bumpy_x, active} !== {11'd64, 1'b0}) begin
      errors++; $display("FAIL midreset_hold: got x=%0d a=%b want 64 0", bumpy_x, active);
    end
    @(negedge clk); resetN = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1; checks++;
    if ({bumpy_x, bumpy_y, active} !== {11'd64, 11'd256, 1'b0}) begin
      errors++; $display("FAIL midreset_after: got x=%0d y=%0d a=%b want 64 256 0", bumpy_x, bumpy_y, active);
    end
    right_key = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0][2:0] a;
    logic l, r, st;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a  = mk_area(rnd_tile(60), rnd_tile(60), rnd_tile(60), rnd_tile(50));
      l  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 99) < 40);
      run_frame(a, l, r, st);
      checks++;
      if ({o_x, o_y, o_death, o_done, o_active} !==
          {px(m_x), px(m_y), e_death, e_done, (m_state == 1)}) begin
        errors++;
        $display("FAIL random f%0d: got x=%0d y=%0d d=%b g=%b a=%b want x=%0d y=%0d d=%b g=%b a=%b",
                 i, o_x, o_y, o_death, o_done, o_active,
                 px(m_x), px(m_y), e_death, e_done, (m_state == 1));
      end
    end
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; start = 1'b0;
    left_key = 1'b0; right_key = 1'b0; area = '0;
    model_reset();
    test_reset();
    test_fall();
    test_land_regu();
    test_spike_death();
    test_gate_vs_fall();
    test_wall();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
